supercar_seq: RTL

- Sequencer for the bouncing shift-register light bar (N_BIT-wide "supercar" scanner).
- Generates the step-enable tick from a programmable prescaler, injects a single seed bit, and counts edge hits (bounces) from pout feedback.
- Stops the scan after a programmed number of bounces, or on stop/fault, then issues a clear pulse.
- Sits between the top-level user controls and the shift-register datapath.

---
 rtl/supercar_pkg.sv | 8 +
 rtl/supercar_prescaler.sv | 27 ++
 rtl/supercar_seq.sv | 102 ++++++++++
 3 files changed

// File: rtl/supercar_pkg.sv
// supercar_pkg: shared state encoding and step-period helper for the supercar sequencer.
package supercar_pkg;
   typedef enum logic [1:0] {IDLE, SEED, RUN, CLEAR} state_t;
   localparam int unsigned BASE_DIV_DEF = 1000;
   function automatic int unsigned step_period(input int unsigned base, input logic [1:0] speed);
      return base << speed;
   endfunction
endpackage

// File: rtl/supercar_prescaler.sv
// supercar_prescaler: step-tick divider; the period is latched from speed on every reload.
module supercar_prescaler
   import supercar_pkg::*;
#(
   parameter int          DIV_W    = 16,
   parameter int unsigned BASE_DIV = BASE_DIV_DEF
)(
   input  logic       clk,
   input  logic       rst,
   input  logic       i_clr,
   input  logic       i_en,
   input  logic [1:0] i_speed,
   output logic       o_tick
);
   logic [DIV_W-1:0] r_cnt, r_lim, w_lim;
   assign w_lim  = DIV_W'(step_period(BASE_DIV, i_speed) - 1);
   assign o_tick = i_en && !i_clr && r_cnt == r_lim;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_cnt <= '0;
         r_lim <= '0;
      end else if (i_clr || o_tick) begin
         r_cnt <= '0;
         r_lim <= w_lim;
      end else if (i_en)
         r_cnt <= r_cnt + 1'b1;
endmodule

// File: rtl/supercar_seq.sv
// supercar_seq: seeds, steps and bounce-counts the supercar light bar, then clears it.
// Define SUPERCAR_SEQ_PAUSE_EN to add a pause input that freezes stepping.
module supercar_seq
   import supercar_pkg::*;
#(
   parameter int          N_BIT    = 8,
   parameter int          DIV_W    = 16,
   parameter int unsigned BASE_DIV = BASE_DIV_DEF,
   parameter int          CNT_W    = 8
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             stop,
`ifdef SUPERCAR_SEQ_PAUSE_EN
   input  logic             pause,
`endif
   input  logic [1:0]       speed,
   input  logic [CNT_W-1:0] n_bounce,
   input  logic [N_BIT-1:0] pos_in,
   output logic             shr_en,
   output logic             shr_sin,
   output logic             shr_clr,
   output logic             busy,
   output logic             done,
   output logic             fault,
   output logic [CNT_W-1:0] bounce_cnt
);
   localparam int ZW = $clog2(N_BIT + 1);
   state_t r_state, w_state_nx;
   logic r_shr_en, r_shr_sin, r_p1, r_p2, r_done_pend, r_done, r_fault;
   logic [CNT_W-1:0] r_cnt, w_cnt_inc;
   logic [ZW-1:0] r_zero;
   logic w_pause, w_tick, w_go, w_eval, w_hit, w_dark, w_complete, w_lost;
`ifdef SUPERCAR_SEQ_PAUSE_EN
   assign w_pause = pause;
`else
   assign w_pause = 1'b0;
`endif
   supercar_prescaler #(.DIV_W(DIV_W), .BASE_DIV(BASE_DIV)) u_pre (
      .clk(clk),
      .rst(rst),
      .i_clr(r_state == IDLE || r_state == CLEAR),
      .i_en((r_state == SEED || r_state == RUN) && !w_pause),
      .i_speed(speed),
      .o_tick(w_tick)
   );
   // pos_in is judged one cycle after shr_en, once the shift register has moved
   assign w_go       = r_state == IDLE && start && !stop;
   assign w_eval     = r_p2 && r_state == RUN;
   assign w_hit      = pos_in[0] || pos_in[N_BIT-1];
   assign w_dark     = pos_in == '0;
   assign w_cnt_inc  = &r_cnt ? r_cnt : r_cnt + 1'b1;
   assign w_complete = w_eval && w_hit && n_bounce != '0 && w_cnt_inc >= n_bounce;
   assign w_lost     = w_eval && w_dark && !w_pause && r_zero == ZW'(N_BIT - 1);
   always_comb begin
      w_state_nx = r_state;
      case (r_state)
         IDLE:    w_state_nx = w_go ? SEED : IDLE;
         SEED:    w_state_nx = stop ? CLEAR : w_tick ? RUN : SEED;
         RUN:     w_state_nx = stop || w_complete || w_lost ? CLEAR : RUN;
         default: w_state_nx = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_state     <= IDLE;
         r_shr_en    <= 1'b0;
         r_shr_sin   <= 1'b0;
         r_p1        <= 1'b0;
         r_p2        <= 1'b0;
         r_done_pend <= 1'b0;
         r_done      <= 1'b0;
         r_fault     <= 1'b0;
         r_cnt       <= '0;
         r_zero      <= '0;
      end else begin
         r_state     <= w_state_nx;
         r_shr_en    <= w_tick;
         r_shr_sin   <= w_tick && r_state == SEED;
         r_p1        <= w_tick && r_state == RUN;
         r_p2        <= r_p1;
         r_done_pend <= !stop && w_complete;
         r_done      <= r_state == CLEAR && r_done_pend;
         r_fault     <= !stop && w_lost;
         if (w_go)
            r_cnt <= '0;
         else if (w_eval && w_hit)
            r_cnt <= w_cnt_inc;
         if (w_go)
            r_zero <= '0;
         else if (w_eval && !w_pause)
            r_zero <= w_dark ? r_zero + 1'b1 : '0;
      end
   assign shr_en     = r_shr_en;
   assign shr_sin    = r_shr_sin;
   assign shr_clr    = r_state == CLEAR;
   assign busy       = r_state != IDLE;
   assign done       = r_done;
   assign fault      = r_fault;
   assign bounce_cnt = r_cnt;
endmodule
